// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and types for the systolic-array run controller.
//   - Default array geometry (N, ACC_W, PE_LAT, CNT_W).
//   - Derived phase lengths for the default geometry.
//   - Run-controller state encoding.
package sa_pkg;

  localparam int unsigned SA_N      = 8;
  localparam int unsigned SA_ACC_W  = 20;
  localparam int unsigned SA_PE_LAT = 1;
  localparam int unsigned SA_CNT_W  = 5;

  localparam int unsigned FEED_LEN  = 2 * SA_N - 1;
  localparam int unsigned DRAIN_LEN = SA_N - 1 + SA_PE_LAT;
  localparam int unsigned NUM_RES   = SA_N * SA_N;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_FEED   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StClear  = ST_CLEAR,
    StFeed   = ST_FEED,
    StDrain  = ST_DRAIN,
    StUnload = ST_UNLOAD
  } sa_state_e;

endpackage

// File: rtl/sa_result_mux.sv
// sa_result_mux: N*N:1 selector picking one ACC_W-wide accumulator out of the flattened
// PE result bus. Entry k lives at i_c_flat[k*ACC_W +: ACC_W].
//   i_c_flat  in   N*N*ACC_W  flattened PE accumulators
//   i_idx     in   IDX_W      row-major entry index
//   o_data    out  ACC_W      selected accumulator (0 for out-of-range index)
module sa_result_mux #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned IDX_W = 10
) (
  input  logic [N*N*ACC_W-1:0] i_c_flat,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [ACC_W-1:0]     o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N * N; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_data = i_c_flat[k*ACC_W +: ACC_W];
      end
    end
  end

endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: run controller for the NxN systolic matrix multiplier.
// Sequence per run: CLEAR (1 cycle) -> FEED (2N-1 cycles, count=1..2N-1) ->
// DRAIN (N-1+PE_LAT cycles) -> UNLOAD (N*N valid/ready handshakes, row-major) -> IDLE + done.
// Optional feature macro: SA_SEQ_PERF_EN (busy-cycle counter on perf_cycles; tied to 0 otherwise).
//   clk          in   1          system clock
//   rst          in   1          asynchronous active-high reset
//   start        in   1          run request, only honoured in IDLE
//   count        out  CNT_W      feed index to operand-feed stage (0 = inject zeros)
//   pe_clr       out  1          clear PE accumulators
//   pe_en        out  1          advance/accumulate PE array
//   c_flat       in   N*N*ACC_W  PE accumulators
//   res_data     out  ACC_W      result element
//   res_idx      out  2*CNT_W    row-major index of res_data
//   res_valid    out  1          result valid
//   res_ready    in   1          downstream accept
//   busy         out  1          run in progress
//   done         out  1          one-cycle completion pulse
//   perf_cycles  out  16         busy-cycle count of the last completed run
module sa_sequencer
  import sa_pkg::*;
#(
  parameter int unsigned N      = SA_N,
  parameter int unsigned ACC_W  = SA_ACC_W,
  parameter int unsigned PE_LAT = SA_PE_LAT,
  parameter int unsigned CNT_W  = SA_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [CNT_W-1:0]     count,
  output logic                 pe_clr,
  output logic                 pe_en,
  input  logic [N*N*ACC_W-1:0] c_flat,
  output logic [ACC_W-1:0]     res_data,
  output logic [2*CNT_W-1:0]   res_idx,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          perf_cycles
);

  localparam int unsigned      IdxW      = 2 * CNT_W;
  localparam logic [CNT_W-1:0] FeedLast  = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(N - 2 + PE_LAT);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(N * N - 1);

  sa_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_phase;
  logic [IdxW-1:0]  r_idx;
  logic             r_done;

  logic             w_start_acc;
  logic             w_hs;
  logic             w_last_hs;
  logic [ACC_W-1:0] w_mux_data;

  assign w_start_acc = (r_state == StIdle) && start;
  assign w_hs        = (r_state == StUnload) && res_ready;
  assign w_last_hs   = w_hs && (r_idx == IdxLast);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (start)                 w_state_next = StClear;
      StClear:                             w_state_next = StFeed;
      StFeed:   if (r_phase == FeedLast)   w_state_next = StDrain;
      StDrain:  if (r_phase == DrainLast)  w_state_next = StUnload;
      StUnload: if (w_last_hs)             w_state_next = StIdle;
      default:                             w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_phase <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last_hs;
      // r_phase doubles as the FEED count (preloaded to 1) and the DRAIN cycle counter.
      case (r_state)
        StClear:         r_phase <= CNT_W'(1);
        StFeed, StDrain: r_phase <= (w_state_next != r_state) ? '0 : r_phase + CNT_W'(1);
        default:         r_phase <= '0;
      endcase
      if (w_hs) begin
        r_idx <= w_last_hs ? '0 : r_idx + IdxW'(1);
      end
    end
  end

  sa_result_mux #(
    .N     (N),
    .ACC_W (ACC_W),
    .IDX_W (IdxW)
  ) u_result_mux (
    .i_c_flat (c_flat),
    .i_idx    (r_idx),
    .o_data   (w_mux_data)
  );

  always_comb begin
    count     = '0;
    pe_clr    = 1'b0;
    pe_en     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_idx   = r_idx;
    busy      = (r_state != StIdle);
    done      = r_done;
    unique case (r_state)
      StClear:  pe_clr = 1'b1;
      StFeed: begin
        pe_en = 1'b1;
        count = r_phase;
      end
      StDrain:  pe_en = 1'b1;
      StUnload: begin
        res_valid = 1'b1;
        res_data  = w_mux_data;
      end
      default: ;
    endcase
  end

`ifdef SA_SEQ_PERF_EN
  logic [15:0] r_perf_cnt;
  logic [15:0] r_perf_out;
  logic [15:0] w_perf_inc;

  assign w_perf_inc = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;

  // The last handshake cycle is itself busy, so the latched value includes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt <= '0;
      r_perf_out <= '0;
    end else begin
      if (w_start_acc) begin
        r_perf_cnt <= '0;
      end else if (r_state != StIdle) begin
        r_perf_cnt <= w_perf_inc;
      end
      if (w_last_hs) begin
        r_perf_out <= w_perf_inc;
      end
    end
  end

  assign perf_cycles = r_perf_out;
`else
  assign perf_cycles = 16'h0;
`endif

endmodule
